// File: rtl/btn_toggle_ctrl_pkg.sv
// btn_pkg: shared FSM encodings and defaults for the button toggle front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DB_CYCLES_DEF = 4;  // default debounce sample count
  localparam int DB_CNT_W      = 8;  // debounce counter width (DB_CYCLES <= 255)

endpackage

// File: rtl/btn_toggle_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // Shift the async level through two flops; both clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/btn_toggle_ctrl.sv
// btn_toggle_ctrl: synchronize, debounce and turn each accepted button press
// into a single-cycle toggle request for a downstream T flip-flop.
module btn_toggle_ctrl
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             t_out,
  output logic             btn_level,
  output logic [CNT_W-1:0] press_cnt
);

  // Last count value before a stable level is accepted.
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                w_s2;
  btn_state_t          r_state;
  btn_state_t          w_state_nxt;
  logic [DB_CNT_W-1:0] r_db_cnt;
  logic [DB_CNT_W-1:0] w_db_nxt;
  logic                w_accept;
  logic                r_t_out;
  logic                r_btn_level;
  logic [CNT_W-1:0]    r_press_cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_s2)
  );

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_t_out     <= 1'b0;
      r_btn_level <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_db_cnt    <= w_db_nxt;
      r_t_out     <= w_accept;
      r_btn_level <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      if (w_accept) r_press_cnt <= r_press_cnt + 1'b1;
    end
  end

  // Next-state and debounce counting; any opposite sample restarts the wait.
  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_s2) begin
          w_state_nxt = PRESS_WAIT;
          w_db_nxt    = DB_CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!w_s2) begin
          w_state_nxt = IDLE;
          w_db_nxt    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = PRESSED;
          w_db_nxt    = '0;
          w_accept    = 1'b1;
        end else begin
          w_db_nxt    = r_db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_s2) begin
          w_state_nxt = RELEASE_WAIT;
          w_db_nxt    = DB_CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (w_s2) begin
          w_state_nxt = PRESSED;
          w_db_nxt    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_db_nxt    = '0;
        end else begin
          w_db_nxt    = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_db_nxt    = '0;
      end
    endcase
  end

  assign t_out     = r_t_out;
  assign btn_level = r_btn_level;
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
// tb_btn_toggle_ctrl: directed checks of debounce, pulse timing, wrap and reset.
module tb_btn_toggle_ctrl;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       t_out;
  logic       btn_level;
  logic [7:0] press_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int btb = 0;
  logic prev_t = 1'b0;
  logic tff_q;

  btn_toggle_ctrl #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .t_out     (t_out),
    .btn_level (btn_level),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Downstream T flip-flop model.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tff_q <= 1'b0;
    else if (t_out) tff_q <= ~tff_q;
  end

  // Pulse counting and back-to-back detection.
  always @(posedge clk) begin
    if (t_out) pulses <= pulses + 1;
    if (t_out && prev_t) btb <= btb + 1;
    prev_t <= t_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  int p0;

  initial begin
    // Reset state
    rst = 1'b1; btn_in = 1'b0;
    ticks(2);
    chk("rst_t_out", 32'(t_out), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_cnt", 32'(press_cnt), 0);
    chk("rst_q", 32'(tff_q), 0);
    rst = 1'b0;
    tick();

    // Clean press: pulse after e5 only
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clean_pre_t", 32'(t_out), 0);
    end
    chk("clean_pre_level", 32'(btn_level), 0);
    tick();
    chk("clean_pulse", 32'(t_out), 1);
    chk("clean_cnt", 32'(press_cnt), 1);
    chk("clean_level", 32'(btn_level), 1);
    tick();
    chk("clean_fall", 32'(t_out), 0);
    chk("clean_tff_q", 32'(tff_q), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clean_hold_t", 32'(t_out), 0);
    end
    chk("clean_hold_cnt", 32'(press_cnt), 1);
    btn_in = 1'b0;
    ticks(5);
    chk("release_level_early", 32'(btn_level), 1);
    ticks(1);
    chk("release_level", 32'(btn_level), 0);
    ticks(2);
    do_reset();

    // Bounce 1,0,1,0 then hold
    btn_in = 1'b1; tick(); chk("bounce_t", 32'(t_out), 0);
    btn_in = 1'b0; tick(); chk("bounce_t", 32'(t_out), 0);
    btn_in = 1'b1; tick(); chk("bounce_t", 32'(t_out), 0);
    btn_in = 1'b0; tick(); chk("bounce_t", 32'(t_out), 0);
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bounce_hold_t", 32'(t_out), 0);
    end
    tick();
    chk("bounce_pulse", 32'(t_out), 1);
    chk("bounce_cnt", 32'(press_cnt), 1);
    tick();
    chk("bounce_fall", 32'(t_out), 0);
    btn_in = 1'b0;
    ticks(8);
    do_reset();

    // Short glitch: 3 cycles high is rejected
    btn_in = 1'b1;
    ticks(3);
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_t", 32'(t_out), 0);
    end
    chk("glitch_cnt", 32'(press_cnt), 0);
    chk("glitch_level", 32'(btn_level), 0);
    chk("glitch_state", 32'(dut.r_state), 32'(IDLE));

    // Exactly DB_CYCLES high is accepted
    btn_in = 1'b1;
    ticks(4);
    btn_in = 1'b0;
    tick();
    chk("min_pre_t", 32'(t_out), 0);
    tick();
    chk("min_pulse", 32'(t_out), 1);
    chk("min_cnt", 32'(press_cnt), 1);
    ticks(8);
    chk("min_release_level", 32'(btn_level), 0);

    // Release glitch while pressed: no second pulse
    btn_in = 1'b1;
    ticks(8);
    chk("press2_cnt", 32'(press_cnt), 2);
    btn_in = 1'b0;
    ticks(3);
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("relglitch_t", 32'(t_out), 0);
      chk("relglitch_level", 32'(btn_level), 1);
    end
    chk("relglitch_cnt", 32'(press_cnt), 2);
    btn_in = 1'b0;
    ticks(8);

    // Reset three cycles into PRESS_WAIT
    btn_in = 1'b1;
    ticks(5);
    rst = 1'b1;
    #1;
    chk("midrst_t", 32'(t_out), 0);
    chk("midrst_level", 32'(btn_level), 0);
    chk("midrst_cnt", 32'(press_cnt), 0);
    ticks(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_pre_t", 32'(t_out), 0);
    end
    tick();
    chk("midrst_pulse", 32'(t_out), 1);
    chk("midrst_cnt1", 32'(press_cnt), 1);
    btn_in = 1'b0;
    ticks(8);
    do_reset();

    // Wrap: 256 press/release pairs
    p0 = pulses;
    for (int k = 0; k < 256; k++) begin
      btn_in = 1'b1;
      ticks(8);
      btn_in = 1'b0;
      ticks(8);
      if (k == 254) chk("wrap_255", 32'(press_cnt), 255);
    end
    chk("wrap_0", 32'(press_cnt), 0);
    chk("wrap_pulses", 32'(pulses - p0), 256);
    chk("no_back_to_back", 32'(btb), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_toggle_ctrl.md
# btn_toggle_ctrl

Upstream stage for the T flip-flop (`tff`). It synchronizes a raw asynchronous push-button input, debounces it with a counter-driven state machine, and emits a single-cycle toggle request `t_out` per accepted press. That pulse drives the `t` input of `tff`. A wrapping press counter and the debounced level are also exported for status and debug.

## Interface
- `DB_CYCLES`, default 4: number of consecutive identical synchronized samples needed to accept a press or a release. Legal range is 2..255.
- `CNT_W`, default 8: width of the `CNT_W`-bit accepted-press counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset; clears every flop, including the synchronizer.
- `btn_in`  input  1: raw, bouncing, asynchronous button level; 1 = pressed.
- `t_out`  output  1: registered one-cycle pulse per accepted press; connects to `tff.t`.
- `btn_level`  output  1: registered debounced level; 1 while in PRESSED or RELEASE_WAIT.
- `press_cnt`  output  `CNT_W`: count of accepted presses; wraps modulo 2^`CNT_W`.

## Operation
- Synchronizer: two flops `s1` → `s2`. The FSM samples only `s2`.
- Debounce counter `db_cnt`: 8 bits, reset value 0.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- IDLE:
  - `s2`=1 → PRESS_WAIT, with `db_cnt`=1.
  - Otherwise stay in IDLE.
- PRESS_WAIT:
  - `s2`=0 → back to IDLE, `db_cnt`=0 (the glitch is rejected, with no partial credit).
  - `s2`=1 and `db_cnt`==`DB_CYCLES`-1 → PRESSED, `db_cnt`=0, `t_out`=1 for the next cycle, `press_cnt`+1.
  - Otherwise `db_cnt`+1.
- PRESSED:
  - `s2`=0 → RELEASE_WAIT, with `db_cnt`=1.
  - Otherwise stay in PRESSED; no further pulses, whatever the hold length.
- RELEASE_WAIT:
  - `s2`=1 → back to PRESSED, `db_cnt`=0.
  - `s2`=0 and `db_cnt`==`DB_CYCLES`-1 → IDLE, `db_cnt`=0.
  - Otherwise `db_cnt`+1.
- `t_out` is a register. It is high for exactly one cycle per IDLE→…→PRESSED acceptance, and never two cycles back to back.
- `press_cnt` increments in the same edge that sets `t_out`. The value 2^`CNT_W`-1 wraps to 0.
- Reset values: `t_out`=0, `btn_level`=0, `press_cnt`=0, `s1`=`s2`=0, state IDLE.
- Reset asserted mid-debounce or mid-press discards all progress immediately and asynchronously. Any pending pulse is never emitted.
- A button held high through reset release counts as a new press once debounced.

## Timing
- Let `btn_in` be stable high before edge e0. Then:
  - `s1`=1 after e0.
  - `s2`=1 after e1.
  - The FSM takes its first sample at e2 (IDLE→PRESS_WAIT).
  - The `DB_CYCLES`-th sample is at e(1+`DB_CYCLES`), which enters PRESSED.
- `t_out` is high in the cycle after e(1+`DB_CYCLES`). With the default of 4, `t_out` rises after e5 and falls after e6.
- Worst-case press-to-pulse latency is 2 + `DB_CYCLES` cycles. Release to IDLE takes the same count.
- `tff` therefore toggles `q` at e(2+`DB_CYCLES`).
- Minimum accepted pulse width on `btn_in` is `DB_CYCLES` cycles. Shorter pulses produce no `t_out` and no count change.

## Structure
- Shared package `btn_pkg`: FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3) and the default `DB_CYCLES`.
- One sub-module, `sync_2ff` (`clk`, `rst`, `d`, `q`): the two-flop synchronizer. It is reused for other async inputs.
- The FSM, debounce counter and press counter stay in `btn_toggle_ctrl`.

## Test plan
All scenarios use `DB_CYCLES`=4, `CNT_W`=8, and a 10-time-unit clock period.
- Reset: `rst`=1 for 2 cycles with `btn_in`=0 → `t_out`=0, `btn_level`=0, `press_cnt`=0.
- Clean press: `btn_in`=1 held for 10 cycles → exactly one `t_out` pulse, high after e5 only. `press_cnt`=1, `btn_level`=1, and the downstream `tff` `q` goes 0→1.
- Bounce: `btn_in` toggles 1,0,1,0 each cycle, then holds 1 → no pulse during the bounce, one pulse 6 cycles after the hold starts, `press_cnt`=1.
- Short glitch: `btn_in`=1 for 3 cycles, then 0 → no `t_out`, `press_cnt` stays 0, FSM returns to IDLE.
- Wrap: 256 clean press/release pairs → 256 pulses; `press_cnt` reads 255, then 0.
- Reset mid-operation: assert `rst` 3 cycles into PRESS_WAIT → all outputs 0 immediately. With `btn_in` still high after release, one pulse follows 6 cycles later.
